// File: rtl/ws2811_frame_ctrl_if.sv
// ws2811_frame_ctrl_if: bundles the host-side write/commit bus, the per-frame controls and
// status, and the driver-side request/pixel handshake of the frame controller.
//   master : host/pattern logic plus driver instance (drives wr_*, commit, enable, brightness,
//            drv_*; observes busy, commit_ack, frame_*, *_out)
//   slave  : ws2811_frame_ctrl
interface ws2811_frame_ctrl_if #(
    parameter int ADDR_W = 2
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;        // {G, R, B}
    logic              commit;
    logic              enable;
    logic [7:0]        brightness;
    logic              busy;
    logic              commit_ack;
    logic              frame_start;
    logic [15:0]       frame_count;
    logic              drv_data_request;
    logic [ADDR_W-1:0] drv_address;
    logic [7:0]        red_out;
    logic [7:0]        green_out;
    logic [7:0]        blue_out;

    modport master (
        output wr_en, wr_addr, wr_data, commit, enable, brightness,
        output drv_data_request, drv_address,
        input  busy, commit_ack, frame_start, frame_count,
        input  red_out, green_out, blue_out
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit, enable, brightness,
        input  drv_data_request, drv_address,
        output busy, commit_ack, frame_start, frame_count,
        output red_out, green_out, blue_out
    );
endinterface

// File: rtl/ws2811_frame_ctrl.sv
// ws2811_frame_ctrl: ping-pong pixel store feeding a ws2811 strip driver.
// The host fills the back bank and commits; banks swap only when the driver requests LED 0,
// so the strip never shows a torn frame. Brightness and blanking are sampled at that same
// boundary and hold for the whole frame.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      ws2811_frame_ctrl_if.slave (write port, commit, enable, brightness, status,
//            driver data_request/address, scaled GRB outputs)
module ws2811_frame_ctrl #(
    parameter int NUM_LEDS = 4,
    parameter int ADDR_W   = $clog2(NUM_LEDS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    ws2811_frame_ctrl_if.slave       bus
);
    localparam int unsigned NumLedsU = NUM_LEDS;

    typedef enum logic {StBlank, StRun} state_e;

    state_e      state_q, state_d;
    logic        front_q, front_d;
    logic        pending_q, pending_d;
    logic [7:0]  bright_q, bright_d;
    logic [15:0] count_q, count_d;
    logic        ack_q, ack_d;
    logic        fstart_q, fstart_d;

    logic [23:0] mem [2*NUM_LEDS];
    logic [23:0] pix_q;

    logic boundary;
    logic swap;
    logic wr_ok;

    assign boundary = bus.drv_data_request && (bus.drv_address == '0);
    // Only the registered pending can swap; a commit on the boundary cycle waits a frame.
    assign swap     = boundary && pending_q;
    assign wr_ok    = bus.wr_en && (32'(bus.wr_addr) < NumLedsU);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StBlank;
            front_q   <= 1'b0;
            pending_q <= 1'b0;
            bright_q  <= 8'hFF;
            count_q   <= 16'd0;
            ack_q     <= 1'b0;
            fstart_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            front_q   <= front_d;
            pending_q <= pending_d;
            bright_q  <= bright_d;
            count_q   <= count_d;
            ack_q     <= ack_d;
            fstart_q  <= fstart_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        front_d   = front_q;
        pending_d = pending_q;
        bright_d  = bright_q;
        count_d   = count_q;
        ack_d     = 1'b0;
        fstart_d  = 1'b0;
        if (swap) begin
            front_d   = ~front_q;
            pending_d = 1'b0;
            ack_d     = 1'b1;
        end else if (bus.commit) begin
            pending_d = 1'b1;
        end
        if (boundary) begin
            bright_d = bus.brightness;
            state_d  = bus.enable ? StRun : StBlank;
            fstart_d = 1'b1;
            count_d  = count_q + 16'd1;
        end
    end

    // Storage: no reset so it maps onto a plain RAM. Host writes always target the back bank.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[{~front_q, bus.wr_addr}] <= bus.wr_data;
        end
    end

    // Read on the boundary cycle must already see the post-swap bank; front_d carries that.
    always_ff @(posedge clk) begin
        if (bus.drv_data_request) begin
            pix_q <= mem[{front_d, bus.drv_address}];
        end
    end

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(c) * (16'(b) + 16'd1);
        return p[15:8];
    endfunction

    // bright_q and state_q update on the same edge as the boundary read, so they always match
    // the pixel currently held in pix_q.
    always_comb begin
        bus.green_out = 8'd0;
        bus.red_out   = 8'd0;
        bus.blue_out  = 8'd0;
        if (state_q == StRun) begin
            bus.green_out = scale(pix_q[23:16], bright_q);
            bus.red_out   = scale(pix_q[15:8], bright_q);
            bus.blue_out  = scale(pix_q[7:0], bright_q);
        end
    end

    assign bus.busy        = pending_q;
    assign bus.commit_ack  = ack_q;
    assign bus.frame_start = fstart_q;
    assign bus.frame_count = count_q;
endmodule

// File: tb/tb_ws2811_frame_ctrl.sv
module tb_ws2811_frame_ctrl;
    localparam int NumLeds = 4;
    localparam int AddrW   = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    ws2811_frame_ctrl_if #(.ADDR_W(AddrW)) bus ();

    ws2811_frame_ctrl #(.NUM_LEDS(NumLeds), .ADDR_W(AddrW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [23:0] rgb;
    logic        ack;
    logic        fs;
    int          fs_cnt;
    int          ack_cnt;

    typedef struct {
        logic [23:0] pix;
        logic [7:0]  bright;
        logic        en;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // One driver request; outputs sampled one cycle later, then one idle cycle.
    task automatic req(input int addr, input logic with_commit);
        @(negedge clk);
        bus.drv_data_request = 1'b1;
        bus.drv_address      = AddrW'(addr);
        bus.commit           = with_commit;
        @(negedge clk);
        bus.drv_data_request = 1'b0;
        bus.commit           = 1'b0;
        rgb = {bus.green_out, bus.red_out, bus.blue_out};
        ack = bus.commit_ack;
        fs  = bus.frame_start;
        fs_cnt  += int'(fs);
        ack_cnt += int'(ack);
        @(negedge clk);
    endtask

    task automatic wr(input int addr, input logic [23:0] data);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AddrW'(addr);
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_commit();
        @(negedge clk);
        bus.commit = 1'b1;
        @(negedge clk);
        bus.commit = 1'b0;
    endtask

    task automatic frame_check(input string tag, input logic [23:0] e0, input logic [23:0] e1,
                               input logic [23:0] e2, input logic [23:0] e3);
        req(0, 1'b0); check({tag, " led0"}, 32'(rgb), 32'(e0));
        req(1, 1'b0); check({tag, " led1"}, 32'(rgb), 32'(e1));
        req(2, 1'b0); check({tag, " led2"}, 32'(rgb), 32'(e2));
        req(3, 1'b0); check({tag, " led3"}, 32'(rgb), 32'(e3));
    endtask

    initial begin
        vecs[0] = '{pix: 24'h112233, bright: 8'd255, en: 1'b1, exp: 24'h112233};
        vecs[1] = '{pix: 24'hFFFF80, bright: 8'd127, en: 1'b1, exp: 24'h7F7F40};
        vecs[2] = '{pix: 24'hFFFFFF, bright: 8'd0,   en: 1'b1, exp: 24'h000000};
        vecs[3] = '{pix: 24'hFFFFFF, bright: 8'd255, en: 1'b0, exp: 24'h000000};
        vecs[4] = '{pix: 24'h80FF01, bright: 8'd63,  en: 1'b1, exp: 24'h203F00};
        vecs[5] = '{pix: 24'h010203, bright: 8'd255, en: 1'b1, exp: 24'h010203};
        vecs[6] = '{pix: 24'hC864FF, bright: 8'd199, en: 1'b1, exp: 24'h9C4EC7};

        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.commit = 1'b0;
        bus.enable = 1'b0; bus.brightness = 8'd255;
        bus.drv_data_request = 1'b0; bus.drv_address = '0;
        fs_cnt = 0; ack_cnt = 0;

        // Reset state
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst busy", 32'(bus.busy), 0);
        check("rst ack", 32'(bus.commit_ack), 0);
        check("rst fstart", 32'(bus.frame_start), 0);
        check("rst count", 32'(bus.frame_count), 0);
        check("rst rgb", 32'({bus.green_out, bus.red_out, bus.blue_out}), 0);

        // Blanked, three free-running frames
        for (int f = 0; f < 3; f++) frame_check("blank", 0, 0, 0, 0);
        check("blank fstarts", fs_cnt, 3);
        check("blank count", 32'(bus.frame_count), 3);
        check("blank busy", 32'(bus.busy), 0);

        // Fill back bank, commit, swap at next boundary
        wr(0, 24'h112233); wr(1, 24'h445566); wr(2, 24'h778899); wr(3, 24'hAABBCC);
        do_commit();
        check("commit busy", 32'(bus.busy), 1);
        bus.enable = 1'b1;
        bus.brightness = 8'd255;
        ack_cnt = 0;
        frame_check("first", 24'h112233, 24'h445566, 24'h778899, 24'hAABBCC);
        check("first ack", ack_cnt, 1);
        check("first busy", 32'(bus.busy), 0);
        check("first count", 32'(bus.frame_count), 4);

        // Table: write back LED0, commit, new enable/brightness, check LED0 of next frame
        foreach (vecs[i]) begin
            wr(0, vecs[i].pix);
            do_commit();
            bus.enable = vecs[i].en;
            bus.brightness = vecs[i].bright;
            req(0, 1'b0);
            check($sformatf("vec%0d rgb", i), 32'(rgb), 32'(vecs[i].exp));
            check($sformatf("vec%0d ack", i), 32'(ack), 1);
            req(1, 1'b0); req(2, 1'b0); req(3, 1'b0);
        end

        // Brightness changed mid-frame waits for the next boundary
        for (int i = 0; i < NumLeds; i++) wr(i, 24'hFFFF80);
        do_commit();
        bus.enable = 1'b1;
        bus.brightness = 8'd127;
        req(0, 1'b0); check("midbr led0", 32'(rgb), 24'h7F7F40);
        req(1, 1'b0); check("midbr led1", 32'(rgb), 24'h7F7F40);
        bus.brightness = 8'd0;
        req(2, 1'b0); check("midbr led2", 32'(rgb), 24'h7F7F40);
        req(3, 1'b0); check("midbr led3", 32'(rgb), 24'h7F7F40);
        req(0, 1'b0); check("midbr next led0", 32'(rgb), 0);
        bus.brightness = 8'd255;
        req(1, 1'b0); req(2, 1'b0); req(3, 1'b0);

        // Commit coincident with the boundary swaps only at the following one
        wr(0, 24'h102030); wr(1, 24'h405060); wr(2, 24'h708090); wr(3, 24'hA0B0C0);
        ack_cnt = 0;
        req(0, 1'b1);
        check("cob led0", 32'(rgb), 24'hFFFF80);
        check("cob ack", 32'(ack), 0);
        check("cob busy", 32'(bus.busy), 1);
        req(1, 1'b0); req(2, 1'b0); req(3, 1'b0);
        do_commit();
        frame_check("cob swap", 24'h102030, 24'h405060, 24'h708090, 24'hA0B0C0);
        req(0, 1'b0); check("cob hold led0", 32'(rgb), 24'h102030);
        req(1, 1'b0); req(2, 1'b0); req(3, 1'b0);
        check("cob ack count", ack_cnt, 1);
        check("cob busy after", 32'(bus.busy), 0);

        // Back-bank write while streaming leaves the front frame alone
        req(0, 1'b0); req(1, 1'b0);
        wr(2, 24'h5A5A5A);
        req(2, 1'b0); check("bkwr front led2", 32'(rgb), 24'h708090);
        req(3, 1'b0);
        do_commit();
        frame_check("bkwr swap", 24'hFFFF80, 24'hFFFF80, 24'h5A5A5A, 24'hFFFF80);
        do_commit();
        frame_check("bkwr back", 24'h102030, 24'h405060, 24'h708090, 24'hA0B0C0);

        // Reset mid-frame with a pending commit
        req(0, 1'b0);
        do_commit();
        check("mrst busy pre", 32'(bus.busy), 1);
        @(negedge clk);
        bus.drv_data_request = 1'b1;
        bus.drv_address = AddrW'(1);
        reset_n = 1'b0;
        #1;
        check("mrst rgb", 32'({bus.green_out, bus.red_out, bus.blue_out}), 0);
        check("mrst busy", 32'(bus.busy), 0);
        check("mrst count", 32'(bus.frame_count), 0);
        check("mrst fstart", 32'(bus.frame_start), 0);
        check("mrst ack", 32'(bus.commit_ack), 0);
        @(negedge clk);
        bus.drv_data_request = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        ack_cnt = 0;
        frame_check("postrst", 24'h102030, 24'h405060, 24'h708090, 24'hA0B0C0);
        check("postrst ack", ack_cnt, 0);
        check("postrst count", 32'(bus.frame_count), 1);
        wr(0, 24'h123456);
        do_commit();
        req(0, 1'b0);
        check("postrst back led0", 32'(rgb), 24'h123456);
        check("postrst back ack", 32'(ack), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ws2811_frame_ctrl.md
Name: ws2811_frame_ctrl

Overview:
Frame scheduler that feeds the ws2811 strip driver from a double-buffered (ping-pong) pixel store.
- Host writes GRB pixels into the back bank, then commits.
- The controller swaps banks only at a frame boundary, so the strip never shows a torn frame.
- It services the driver's data_request/address handshake and applies global brightness and blanking per frame.
- It sits between the host/pattern logic and the ws2811 driver instance.

Parameters:
NUM_LEDS, 4, LEDs in chain; power of two, >=2; must match the driver instance.
ADDR_W, clog2(NUM_LEDS), LED address width; must match the driver address width.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
wr_en  in  1  write strobe into back bank
wr_addr  in  ADDR_W  LED index to write
wr_data  in  24  pixel {G[23:16],R[15:8],B[7:0]}
commit  in  1  pulse: back bank complete, request swap
enable  in  1  1 = stream pixels; 0 = blank strip
brightness  in  8  global brightness, sampled per frame
busy  out  1  commit pending (swap not yet done)
commit_ack  out  1  one-cycle pulse on the swap cycle
frame_start  out  1  one-cycle pulse at each frame boundary
frame_count  out  16  frames started since reset, wraps
drv_data_request  in  1  from driver data_request
drv_address  in  ADDR_W  from driver address
red_out  out  8  to driver red_in
green_out  out  8  to driver green_in
blue_out  out  8  to driver blue_in

Behaviour:
- Reset (async assert, sync release) clears: front=0, pending=0, state=BLANK, busy=0, commit_ack=0, frame_start=0, frame_count=0, rgb outputs=0, bright_q=255. RAM contents are not reset.
- Storage: 2*NUM_LEDS x 24 RAM, address {bank, led}.
  - Write port: write to {~front, wr_addr} when wr_en=1.
  - wr_addr >= NUM_LEDS: ignored.
  - Writes are accepted in every state and never touch the front bank.
- Frame boundary (B): drv_data_request=1 && drv_address==0, i.e. the request for LED 0.
- Commit:
  - commit=1 sets pending next edge; busy = pending.
  - Commit while pending: no effect.
  - Commit coincident with B: becomes pending and swaps at the following B. The swap only ever uses the registered pending.
- At the B edge, all evaluated with values before the edge:
  - If pending: front toggles, pending clears, commit_ack=1 for that cycle.
  - bright_q <= brightness.
  - state <= enable ? RUN : BLANK.
  - frame_start=1, frame_count += 1 (wraps 0xFFFF->0).
- The read issued on the B cycle uses the post-swap bank and the newly sampled enable/brightness. These are computed combinationally from pending, enable and brightness for that cycle.
- Read/handshake:
  - On every cycle with drv_data_request=1, the RAM reads {front_next, drv_address}.
  - red/green/blue_out are valid exactly 1 cycle later, when the driver latches them.
  - They hold until the next request.
  - Outside requests, the RAM read is disabled and the outputs stay stable.
- Scaling: out_c = (c * (bright+1)) >> 8.
  - Intermediate is 16 bits, result [15:8].
  - bright=255 is identity; bright=0 gives 0 for all c.
  - Applied combinationally after the RAM register, within the same 1-cycle latency.
- BLANK state forces all three outputs to 0 regardless of RAM. BLANK/RUN changes only at B, so there are no partial frames.
- enable or brightness changed mid-frame: no effect until next B.
- reset_n asserted mid-frame: immediate clear. Pending commit is lost and front returns to bank 0. The host must rewrite and recommit.

Test Plan:
- Reset, enable=0, driver free-running 3 frames -> rgb_out=0 every latch, frame_start pulses 3x, frame_count=3, busy=0.
- Write LED0..3 = 0x112233,0x445566,0x778899,0xAABBCC; commit; enable=1; brightness=255 -> busy=1 until next B. commit_ack on B, then green/red/blue_out=0x11/0x22/0x33 one cycle after request for LED0, then LED1..3 in order.
- Brightness=127 with pixel 0xFFFF80 -> outputs G=0x7F, R=0x7F, B=0x40. Brightness changed mid-frame to 0 -> takes effect only from next frame's LED0.
- Commit asserted in same cycle as B -> no swap that frame. Swap + commit_ack at the next B; second commit while busy produces one ack only.
- While streaming, overwrite back bank LED2 and write wr_addr beyond range -> front-frame output unchanged. After commit+swap, LED2 shows new value; no RAM alias corruption.
- Assert reset_n low during LED1 of a frame with pending commit -> all outputs 0, busy=0, frame_count=0, front=bank0. No commit_ack after release.
